pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Control-side partner of the next-PC mux: a sequencer that drives pc_src, pc_in_sel and the PC write enable every cycle.
- Runs the reset-vector fetch, interrupt entry, RET/RTI return and branch redirect sequences.
- Sits in the fetch stage. Its outputs connect directly to the mux selects, the PC register enable, the pipeline flush, the stack push and the vector-memory read port.

Parameters:
- VEC_LAT, 1, cycles from vec_rd to valid vector data at the mux reset_addr/interrupt_addr inputs (1..7).
- RET_TIMEOUT, 15, maximum cycles spent in RET_WAIT before abandoning the return (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard stall; holds the PC in RUN.
- branch_taken  input  1  branch resolved taken this cycle.
- ret_req  input  1  RET/RTI in execute; pulse.
- is_rti  input  1  qualifies ret_req as RTI.
- stack_valid  input  1  popped return address is valid at the mux stack_addr input.
- int_req  input  1  external interrupt, level-sensitive.
- pc_src  output  1  0 = pc_plus_1, 1 = use pc_in_sel.
- pc_in_sel  output  2  00 = interrupt_addr, 01 = stack_addr, 10 = branch_addr, 11 = reset_addr.
- pc_we  output  1  PC register load enable.
- flush  output  1  squash fetch/decode.
- push_pc  output  1  push current PC to stack; one-cycle pulse.
- vec_rd  output  1  vector memory read strobe.
- vec_sel  output  1  0 = reset vector (M[0]), 1 = interrupt vector (M[1]).
- int_ack  output  1  interrupt accepted; one-cycle pulse.
- ret_err  output  1  return timeout; one-cycle pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to RST_VEC, in_isr clears, wait counter clears.
  - All outputs are 0.
  - Reset asserted at any point, mid-sequence included, aborts the sequence; nothing is completed.
- All outputs are registered from the state. Unlisted outputs are 0 in each state.
- States:
  - RST_VEC: vec_rd=1, vec_sel=0, flush=1. Counter runs VEC_LAT cycles, then goes to RST_LOAD.
  - RST_LOAD: pc_src=1, pc_in_sel=11, pc_we=1, flush=1. Goes to RUN.
  - RUN: evaluates in priority order:
    1. branch_taken: pc_src=1, sel=10, pc_we=1, flush=1. Stays in RUN. Overrides stall.
    2. ret_req: goes to RET_WAIT. flush=1, pc_we=0.
    3. int_req & !in_isr & !stall: goes to INT_PUSH.
    4. stall: pc_we=0, pc_src=0.
    5. Otherwise: pc_src=0, pc_we=1 (sequential fetch).
  - INT_PUSH: push_pc=1, flush=1, pc_we=0. Goes to INT_VEC.
  - INT_VEC: vec_rd=1, vec_sel=1, flush=1. Counter runs VEC_LAT cycles, then goes to INT_LOAD.
  - INT_LOAD: pc_src=1, sel=00, pc_we=1, flush=1, int_ack=1. Sets in_isr. Goes to RUN.
  - RET_WAIT: flush=1, pc_we=0, wait counter increments each cycle.
    - If stack_valid: pc_src=1, sel=01, pc_we=1. If is_rti was latched at ret_req, in_isr clears. Goes to RUN.
    - If counter reaches RET_TIMEOUT without stack_valid: ret_err=1, pc_we=0. Goes to RUN; PC is unchanged.
- Interrupt and branch in the same RUN cycle: the branch is taken. The interrupt stays pending because int_req is level and is re-evaluated next cycle.
- Interrupt and ret_req in the same cycle: the ret is taken. An RTI clears in_isr, so the still-pending interrupt can enter on the next RUN cycle.
- int_req while in_isr=1: ignored; no nesting.
- stack_valid is ignored outside RET_WAIT.
- ret_req outside RUN is ignored.
- Counters saturate at 0 on state entry. No wrap is possible.

Test Plan:
- Reset release, VEC_LAT=1: rst_n 0→1.
  - Cycle 1: vec_rd=1, vec_sel=0.
  - Cycle 2: pc_src=1, pc_in_sel=11, pc_we=1.
  - Cycle 3: pc_src=0, pc_we=1.
- Interrupt entry: int_req=1 in RUN with stall=0.
  - push_pc pulse, then vec_rd with vec_sel=1, then sel=00 with pc_we=1 and int_ack=1. Total 3 cycles with flush=1.
  - A second int_req before RTI produces no ack.
- RTI: ret_req=1, is_rti=1, stack_valid rises after 3 cycles.
  - pc_we=0 for 3 cycles, then sel=01 with pc_we=1.
  - in_isr clears; a held int_req is acked again.
- Simultaneous branch_taken=1 and int_req=1:
  - Cycle 1: sel=10, pc_we=1, flush=1, no push_pc.
  - Next cycle: interrupt entry begins.
- Return timeout, RET_TIMEOUT=15: ret_req with stack_valid held 0.
  - ret_err pulses 15 cycles after ret_req, then back in RUN with the PC unchanged.
- Stall in RUN: pc_we=0 while stalled. branch_taken during stall still gives pc_we=1, sel=10. rst_n low in INT_VEC returns all outputs to 0 immediately and restarts RST_VEC.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage sequencer for the next-PC mux.
// Drives the mux selects, PC load enable, flush, stack push and vector-memory
// read strobe for the reset-vector fetch, interrupt entry, RET/RTI return and
// branch redirect sequences. Every output is a flop: the value shown in a
// cycle is the action the FSM took at the preceding rising edge.
module pc_ctrl #(
  parameter int unsigned VEC_LAT     = 1,   // vec_rd to valid vector data, 1..7
  parameter int unsigned RET_TIMEOUT = 15   // max cycles in RET_WAIT, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       ret_req,
  input  logic       is_rti,
  input  logic       stack_valid,
  input  logic       int_req,
  output logic       pc_src,
  output logic [1:0] pc_in_sel,
  output logic       pc_we,
  output logic       flush,
  output logic       push_pc,
  output logic       vec_rd,
  output logic       vec_sel,
  output logic       int_ack,
  output logic       ret_err
);

  // Mux select encodings for pc_in_sel.
  localparam logic [1:0] SEL_INT    = 2'b00;
  localparam logic [1:0] SEL_STACK  = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_RESET  = 2'b11;

  // Last counter value before leaving a vector-read or return-wait state.
  localparam logic [7:0] VEC_LAST = 8'(VEC_LAT - 1);
  localparam logic [7:0] RET_LAST = 8'(RET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RST_VEC  = 3'd0,
    ST_RST_LOAD = 3'd1,
    ST_RUN      = 3'd2,
    ST_INT_PUSH = 3'd3,
    ST_INT_VEC  = 3'd4,
    ST_INT_LOAD = 3'd5,
    ST_RET_WAIT = 3'd6
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;      // vector-latency / return-wait counter, cleared on entry
  logic       in_isr_q;   // inside an interrupt handler; blocks nesting
  logic       rti_q;      // the pending return was an RTI

  logic       pc_src_q;
  logic [1:0] pc_in_sel_q;
  logic       pc_we_q;
  logic       flush_q;
  logic       push_pc_q;
  logic       vec_rd_q;
  logic       vec_sel_q;
  logic       int_ack_q;
  logic       ret_err_q;

  // Sequencer: next state, counters, handler flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_VEC;
      cnt_q       <= 8'd0;
      in_isr_q    <= 1'b0;
      rti_q       <= 1'b0;
      pc_src_q    <= 1'b0;
      pc_in_sel_q <= 2'b00;
      pc_we_q     <= 1'b0;
      flush_q     <= 1'b0;
      push_pc_q   <= 1'b0;
      vec_rd_q    <= 1'b0;
      vec_sel_q   <= 1'b0;
      int_ack_q   <= 1'b0;
      ret_err_q   <= 1'b0;
    end else begin
      // Outputs not driven by the current action fall back to 0.
      pc_src_q    <= 1'b0;
      pc_in_sel_q <= 2'b00;
      pc_we_q     <= 1'b0;
      flush_q     <= 1'b0;
      push_pc_q   <= 1'b0;
      vec_rd_q    <= 1'b0;
      vec_sel_q   <= 1'b0;
      int_ack_q   <= 1'b0;
      ret_err_q   <= 1'b0;

      case (state_q)
        ST_RST_VEC: begin
          vec_rd_q <= 1'b1;
          flush_q  <= 1'b1;
          if (cnt_q >= VEC_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= ST_RST_LOAD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_RST_LOAD: begin
          pc_src_q    <= 1'b1;
          pc_in_sel_q <= SEL_RESET;
          pc_we_q     <= 1'b1;
          flush_q     <= 1'b1;
          state_q     <= ST_RUN;
        end

        ST_RUN: begin
          if (branch_taken) begin
            // A resolved branch wins over stall, return and interrupt.
            pc_src_q    <= 1'b1;
            pc_in_sel_q <= SEL_BRANCH;
            pc_we_q     <= 1'b1;
            flush_q     <= 1'b1;
          end else if (ret_req) begin
            flush_q <= 1'b1;
            rti_q   <= is_rti;
            cnt_q   <= 8'd0;
            state_q <= ST_RET_WAIT;
          end else if (int_req && !in_isr_q && !stall) begin
            // PC holds this cycle so the pushed PC is the next unexecuted one.
            cnt_q   <= 8'd0;
            state_q <= ST_INT_PUSH;
          end else if (stall) begin
            pc_we_q <= 1'b0;
          end else begin
            pc_we_q <= 1'b1;
          end
        end

        ST_INT_PUSH: begin
          push_pc_q <= 1'b1;
          flush_q   <= 1'b1;
          cnt_q     <= 8'd0;
          state_q   <= ST_INT_VEC;
        end

        ST_INT_VEC: begin
          vec_rd_q  <= 1'b1;
          vec_sel_q <= 1'b1;
          flush_q   <= 1'b1;
          if (cnt_q >= VEC_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= ST_INT_LOAD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_INT_LOAD: begin
          pc_src_q    <= 1'b1;
          pc_in_sel_q <= SEL_INT;
          pc_we_q     <= 1'b1;
          flush_q     <= 1'b1;
          int_ack_q   <= 1'b1;
          in_isr_q    <= 1'b1;
          state_q     <= ST_RUN;
        end

        ST_RET_WAIT: begin
          flush_q <= 1'b1;
          if (stack_valid) begin
            pc_src_q    <= 1'b1;
            pc_in_sel_q <= SEL_STACK;
            pc_we_q     <= 1'b1;
            if (rti_q) begin
              in_isr_q <= 1'b0;
            end else begin
              in_isr_q <= in_isr_q;
            end
            cnt_q   <= 8'd0;
            state_q <= ST_RUN;
          end else if (cnt_q >= RET_LAST) begin
            // Give up on the return; PC is left untouched.
            ret_err_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          cnt_q   <= 8'd0;
          state_q <= ST_RST_VEC;
        end
      endcase
    end
  end

  assign pc_src    = pc_src_q;
  assign pc_in_sel = pc_in_sel_q;
  assign pc_we     = pc_we_q;
  assign flush     = flush_q;
  assign push_pc   = push_pc_q;
  assign vec_rd    = vec_rd_q;
  assign vec_sel   = vec_sel_q;
  assign int_ack   = int_ack_q;
  assign ret_err   = ret_err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed bench for pc_ctrl with a sequence-level model.
// Output vector layout: {pc_src, pc_in_sel[1:0], pc_we, flush, push_pc,
// vec_rd, vec_sel, int_ack, ret_err}.
module tb_pc_ctrl;

  localparam int unsigned VEC_LAT     = 1;
  localparam int unsigned RET_TIMEOUT = 15;

  localparam logic [9:0] IDLE  = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] RVEC  = 10'b0_00_0_1_0_1_0_0_0;
  localparam logic [9:0] RLOAD = 10'b1_11_1_1_0_0_0_0_0;
  localparam logic [9:0] SEQ   = 10'b0_00_1_0_0_0_0_0_0;
  localparam logic [9:0] BR    = 10'b1_10_1_1_0_0_0_0_0;
  localparam logic [9:0] FLUSH = 10'b0_00_0_1_0_0_0_0_0;
  localparam logic [9:0] PUSH  = 10'b0_00_0_1_1_0_0_0_0;
  localparam logic [9:0] IVEC  = 10'b0_00_0_1_0_1_1_0_0;
  localparam logic [9:0] ILOAD = 10'b1_00_1_1_0_0_0_1_0;
  localparam logic [9:0] RLD   = 10'b1_01_1_1_0_0_0_0_0;
  localparam logic [9:0] ERR   = 10'b0_00_0_1_0_0_0_0_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, branch_taken = 1'b0, ret_req = 1'b0, is_rti = 1'b0;
  logic       stack_valid = 1'b0, int_req = 1'b0;
  logic       pc_src, pc_we, flush, push_pc, vec_rd, vec_sel, int_ack, ret_err;
  logic [1:0] pc_in_sel;
  logic [9:0] dut_v;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  pc_ctrl #(.VEC_LAT(VEC_LAT), .RET_TIMEOUT(RET_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .ret_req(ret_req), .is_rti(is_rti), .stack_valid(stack_valid),
    .int_req(int_req), .pc_src(pc_src), .pc_in_sel(pc_in_sel), .pc_we(pc_we),
    .flush(flush), .push_pc(push_pc), .vec_rd(vec_rd), .vec_sel(vec_sel),
    .int_ack(int_ack), .ret_err(ret_err)
  );

  assign dut_v = {pc_src, pc_in_sel, pc_we, flush, push_pc, vec_rd, vec_sel, int_ack, ret_err};

  always #5 clk = ~clk;

  // Model: whole sequences are queued when they start; RUN decisions and the
  // open-ended return wait are resolved from the inputs seen at each edge.
  logic [9:0] exp_cur = 10'd0;
  logic [9:0] exp_q[$];
  bit         isr = 1'b0;
  bit         ret_active = 1'b0;
  bit         ret_rti = 1'b0;
  int         ret_age = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cur = IDLE;
      exp_q.delete();
      for (int i = 0; i < int'(VEC_LAT); i++) exp_q.push_back(RVEC);
      exp_q.push_back(RLOAD);
      isr = 1'b0;
      ret_active = 1'b0;
      ret_age = 0;
    end else if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
      if (exp_cur[1]) isr = 1'b1;
    end else if (ret_active) begin
      ret_age++;
      if (stack_valid) begin
        exp_cur = RLD;
        if (ret_rti) isr = 1'b0;
        ret_active = 1'b0;
      end else if (ret_age == int'(RET_TIMEOUT)) begin
        exp_cur = ERR;
        ret_active = 1'b0;
      end else begin
        exp_cur = FLUSH;
      end
    end else if (branch_taken) begin
      exp_cur = BR;
    end else if (ret_req) begin
      exp_cur = FLUSH;
      ret_active = 1'b1;
      ret_age = 0;
      ret_rti = is_rti;
    end else if (int_req && !isr && !stall) begin
      exp_cur = IDLE;
      exp_q.push_back(PUSH);
      for (int i = 0; i < int'(VEC_LAT); i++) exp_q.push_back(IVEC);
      exp_q.push_back(ILOAD);
    end else if (stall) begin
      exp_cur = IDLE;
    end else begin
      exp_cur = SEQ;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (dut_v !== exp_cur) begin
        failures++;
        $display("FAIL model t=%0t got=%b exp=%b", $time, dut_v, exp_cur);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pin(input string nm, input logic [9:0] e);
    checks++;
    if (dut_v !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, dut_v, e);
    end
  endtask

  initial begin
    tick(); tick();
    check_en = 1'b1;
    tick(); pin("reset_zero", IDLE);
    rst_n = 1'b1;
    tick(); pin("rst_vec", RVEC);
    tick(); pin("rst_load", RLOAD);
    tick(); pin("run_seq", SEQ);

    // Interrupt entry, then a held int_req inside the handler is ignored.
    int_req = 1'b1;
    tick(); pin("int_decide", IDLE);
    tick(); pin("int_push", PUSH);
    tick(); pin("int_vec", IVEC);
    tick(); pin("int_load", ILOAD);
    tick(); pin("no_nest1", SEQ);
    tick(); pin("no_nest2", SEQ);

    // RTI with stack_valid arriving on the third wait cycle.
    ret_req = 1'b1; is_rti = 1'b1;
    tick(); pin("rti_flush", FLUSH);
    ret_req = 1'b0; is_rti = 1'b0;
    tick(); pin("rti_wait1", FLUSH);
    tick(); pin("rti_wait2", FLUSH);
    stack_valid = 1'b1;
    tick(); pin("rti_load", RLD);
    stack_valid = 1'b0;
    tick(); pin("reint_decide", IDLE);
    tick(); pin("reint_push", PUSH);
    tick();
    tick(); pin("reint_ack", ILOAD);
    int_req = 1'b0;
    tick(); pin("post_isr_seq", SEQ);

    // Fast RTI: stack already valid on the first wait cycle.
    ret_req = 1'b1; is_rti = 1'b1; stack_valid = 1'b1;
    tick();
    ret_req = 1'b0; is_rti = 1'b0;
    tick(); pin("rti_fast", RLD);
    stack_valid = 1'b0;

    // Branch and interrupt together: branch first, interrupt next cycle.
    branch_taken = 1'b1; int_req = 1'b1;
    tick(); pin("br_int", BR);
    branch_taken = 1'b0;
    tick(); pin("br_int_next", IDLE);
    tick(); pin("br_int_push", PUSH);
    tick();
    tick(); pin("br_int_ack", ILOAD);
    int_req = 1'b0;
    tick();

    // Return timeout with stack_valid held low.
    ret_req = 1'b1;
    tick(); pin("to_flush", FLUSH);
    ret_req = 1'b0;
    for (int i = 0; i < int'(RET_TIMEOUT) - 1; i++) tick();
    tick(); pin("ret_err", ERR);
    tick(); pin("after_err", SEQ);

    // Stall holds the PC; a branch still redirects during stall.
    stall = 1'b1; int_req = 1'b1;
    tick(); pin("stall", IDLE);
    branch_taken = 1'b1;
    tick(); pin("stall_br", BR);
    branch_taken = 1'b0;
    tick(); pin("stall2", IDLE);
    stall = 1'b0; int_req = 1'b0;
    tick(); pin("unstall", SEQ);

    // Leave the handler, then reset in the middle of interrupt entry.
    ret_req = 1'b1; is_rti = 1'b1; stack_valid = 1'b1;
    tick();
    ret_req = 1'b0; is_rti = 1'b0;
    tick();
    stack_valid = 1'b0;
    int_req = 1'b1;
    tick(); pin("mid_decide", IDLE);
    tick(); pin("mid_push", PUSH);
    #2 rst_n = 1'b0;
    #1 pin("mid_reset", IDLE);
    int_req = 1'b0;
    tick(); tick(); pin("held_reset", IDLE);
    rst_n = 1'b1;
    tick(); pin("rst2_vec", RVEC);
    tick(); pin("rst2_load", RLOAD);
    tick(); pin("rst2_seq", SEQ);

    // Stall blocks interrupt entry; entry proceeds once stall drops.
    stall = 1'b1; int_req = 1'b1;
    tick(); pin("stall_int", IDLE);
    stall = 1'b0;
    tick(); tick(); pin("stall_int_push", PUSH);
    int_req = 1'b0;
    tick(); tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
